sum_display_scanner: RTL and testbench

//  Downstream stage of the 4-bit ripple-carry adder on the FPGA board: captures the 5-bit

---
 rtl/sum_display_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/sum_display_scanner.sv | 104 ++++++++++
 tb/tb_sum_display_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_display_pkg.sv
// Shared types and constants for the adder-result display scanner.
// Holds the FSM encoding, 7-segment codes and the double-dabble step count.
package sum_display_pkg;

  typedef enum logic {StIdle, StConvert} state_e;

  localparam int unsigned DD_STEPS = 5;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
// Codes above 9 decode to blank.
module bcd_to_seg7
  import sum_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg_n = SEG_0;
        4'd1:    o_seg_n = SEG_1;
        4'd2:    o_seg_n = SEG_2;
        4'd3:    o_seg_n = SEG_3;
        4'd4:    o_seg_n = SEG_4;
        4'd5:    o_seg_n = SEG_5;
        4'd6:    o_seg_n = SEG_6;
        4'd7:    o_seg_n = SEG_7;
        4'd8:    o_seg_n = SEG_8;
        4'd9:    o_seg_n = SEG_9;
        default: o_seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_display_scanner.sv
// Captures a 5-bit adder result, converts it to two BCD digits by sequential
// double-dabble and scans them onto a 2-digit common-anode 7-segment display.
module sum_display_scanner
  import sum_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum_in,
  input  logic       load,
  output logic       ready,
  output logic [6:0] seg_n,
  output logic [1:0] an_n
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e         r_state, w_state_d;
  logic [2:0]     r_step;
  logic [4:0]     r_bin;
  logic [7:0]     r_bcd;
  logic [3:0]     r_tens, r_ones;
  logic [CntW-1:0] r_scan_cnt;
  logic           r_digit_sel;

  logic [7:0]  w_bcd_adj;
  logic [12:0] w_cat, w_shift;
  logic        w_last, w_accept, w_blank;
  logic [3:0]  w_digit;

  // One double-dabble step: correct nibbles >=5, then shift {bcd,bin} left.
  assign w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  assign w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
  assign w_cat    = {w_bcd_adj, r_bin};
  assign w_shift  = w_cat << 1;
  assign w_last   = (r_step == 3'(DD_STEPS - 1));
  assign w_accept = (r_state == StIdle) && load;
  assign ready    = (r_state == StIdle);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (load) w_state_d = StConvert;
      StConvert: if (w_last) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else if (w_accept) begin
      r_step <= '0;
      r_bin  <= sum_in;
      r_bcd  <= '0;
    end else if (r_state == StConvert) begin
      r_step <= r_step + 3'd1;
      r_bcd  <= w_shift[12:5];
      r_bin  <= w_shift[4:0];
      // Shown digits change only here so the display never sees partial results.
      if (w_last) begin
        r_tens <= w_shift[12:9];
        r_ones <= w_shift[8:5];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= 1'b0;
    end else if (r_scan_cnt == CntW'(REFRESH_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= ~r_digit_sel;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign an_n    = r_digit_sel ? 2'b01 : 2'b10;
  assign w_digit = r_digit_sel ? r_tens : r_ones;
  assign w_blank = r_digit_sel && (BLANK_LZ != 0) && (r_tens == 4'd0);

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_bcd   (w_digit),
    .i_blank (w_blank),
    .o_seg_n (seg_n)
  );

endmodule

// File: tb/tb_sum_display_scanner.sv
// Directed, table-driven bench for sum_display_scanner with a short scan period.
// A second instance with leading-zero blanking disabled shares the same stimulus.
module tb_sum_display_scanner;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum_in = '0;
  logic       load = 1'b0;
  logic       ready, ready_nb;
  logic [6:0] seg_n, seg_n_nb;
  logic [1:0] an_n, an_n_nb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_display_scanner #(.REFRESH_DIV(Div), .BLANK_LZ(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sum_in (sum_in),
    .load   (load),
    .ready  (ready),
    .seg_n  (seg_n),
    .an_n   (an_n)
  );

  sum_display_scanner #(.REFRESH_DIV(Div), .BLANK_LZ(0)) dut_nb (
    .clk    (clk),
    .rst_n  (rst_n),
    .sum_in (sum_in),
    .load   (load),
    .ready  (ready_nb),
    .seg_n  (seg_n_nb),
    .an_n   (an_n_nb)
  );

  typedef struct {
    logic [4:0] val;
    logic [6:0] tens;
    logic [6:0] ones;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] tens_seg(input int v, input bit blank_lz);
    if (blank_lz && (v / 10) == 0) return 7'b1111111;
    return seg_of(v / 10);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse load at the next edge and count cycles with ready low afterwards.
  task automatic do_load(input logic [4:0] v);
    int cnt = 0;
    while (!ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("ready_before_load", 16'(ready), 16'd1);
    sum_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    sum_in = 5'd0;
    cnt = 0;
    while (!ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 16'(cnt), 16'd5);
  endtask

  // Watch a full scan period and compare what each digit position shows.
  task automatic check_display(input string name, input logic [6:0] exp_tens,
                               input logic [6:0] exp_ones, input logic [6:0] exp_tens_nb);
    logic [6:0] t = 'x, o = 'x, tnb = 'x;
    bit bad_an = 0;
    for (int i = 0; i < 2 * Div + 2; i++) begin
      if (an_n == 2'b10) o = seg_n;
      else if (an_n == 2'b01) t = seg_n;
      else bad_an = 1;
      if (an_n_nb == 2'b01) tnb = seg_n_nb;
      @(negedge clk);
    end
    chk({name, "_an_onehot"}, 16'(bad_an), 16'd0);
    chk({name, "_tens"}, 16'(t), 16'(exp_tens));
    chk({name, "_ones"}, 16'(o), 16'(exp_ones));
    chk({name, "_tens_nolz"}, 16'(tnb), 16'(exp_tens_nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'd27, 7'b0100100, 7'b1111000};
    vecs[1] = '{5'd31, 7'b0110000, 7'b1111001};
    vecs[2] = '{5'd9,  7'b1111111, 7'b0010000};
    vecs[3] = '{5'd0,  7'b1111111, 7'b1000000};
    vecs[4] = '{5'd10, 7'b1111001, 7'b1000000};
    vecs[5] = '{5'd19, 7'b1111001, 7'b0010000};
    vecs[6] = '{5'd25, 7'b0100100, 7'b0010010};
    vecs[7] = '{5'd16, 7'b1111001, 7'b0000010};

    // Reset state and free-running scan.
    #1;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_an", 16'(an_n), 16'b10);
    chk("rst_seg", 16'(seg_n), 16'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [1:0] exp_an;
      exp_an = ((k / Div) % 2 == 1) ? 2'b01 : 2'b10;
      chk("scan_an", 16'(an_n), 16'(exp_an));
      chk("scan_seg", 16'(seg_n), (exp_an == 2'b10) ? 16'b1000000 : 16'b1111111);
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      do_load(v.val);
      check_display($sformatf("vec%0d", v.val), v.tens, v.ones,
                    (v.tens == 7'b1111111) ? 7'b1000000 : v.tens);
    end

    // Load during CONVERT is ignored.
    sum_in = 5'd12; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    sum_in = 5'd30; load = 1'b1;
    @(negedge clk);
    load = 1'b0; sum_in = 5'd0;
    for (int c = 0; c < 10 && !ready; c++) @(negedge clk);
    check_display("ignore12", 7'b1111001, 7'b0100100, 7'b1111001);
    do_load(5'd30);
    check_display("fresh30", 7'b0110000, 7'b1000000, 7'b0110000);

    // Shown value holds through CONVERT and switches only at commit.
    do_load(5'd18);
    sum_in = 5'd20; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      int v;
      v = (k < 5) ? 18 : 20;
      chk($sformatf("hold_k%0d", k), 16'(seg_n),
          16'((an_n == 2'b01) ? tens_seg(v, 1'b1) : seg_of(v % 10)));
      @(negedge clk);
    end

    // Reset in the middle of a conversion.
    sum_in = 5'd25; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 16'(ready), 16'd1);
    chk("midrst_an", 16'(an_n), 16'b10);
    chk("midrst_seg", 16'(seg_n), 16'b1000000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_display("after_rst", 7'b1111111, 7'b1000000, 7'b1000000);

    // Full sweep against the decimal model.
    for (int v = 0; v < 32; v++) begin
      do_load(5'(v));
      check_display($sformatf("sweep%0d", v), tens_seg(v, 1'b1), seg_of(v % 10),
                    tens_seg(v, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
